// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU op codes and the ID/EX register layout
package alu_pkg;
    localparam int XLEN = 32;
    localparam int REG_AW = 5;
    localparam int ALUCTRL_W = 4;
    localparam logic [ALUCTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALUCTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALUCTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALUCTRL_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALUCTRL_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [ALUCTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALUCTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALUCTRL_W-1:0] ALU_SRA = 4'b1101;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 mem_read;
        logic                 mem_write;
        logic                 alu_src_a;
        logic                 alu_src_b;
        logic [ALUCTRL_W-1:0] alu_ctrl;
        logic [REG_AW-1:0]    rs1;
        logic [REG_AW-1:0]    rs2;
        logic [REG_AW-1:0]    rd;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      rd1;
        logic [XLEN-1:0]      rd2;
        logic [XLEN-1:0]      imm;
    } ex_regs_t;

    // A bubble carries a legal ALU op so the ALU never sees an undefined code
    function automatic ex_regs_t ex_bubble();
        ex_regs_t b;
        b = '0;
        b.alu_ctrl = ALU_ADD;
        return b;
    endfunction
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: priority operand forwarding, MEM over WB over register file, x0 never forwarded
module fwd_mux
    import alu_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [XLEN-1:0]   mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   data
);
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_reg_write && mem_rd != '0 && mem_rd == rs;
        wb_hit  = wb_reg_write && wb_rd != '0 && wb_rd == rs;
        data    = mem_hit ? mem_result : wb_hit ? wb_result : reg_data;
    end
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with load-use bubble insertion and EX operand forwarding
module id_ex_operand_stage
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_rd1,
    input  logic [XLEN-1:0]      id_rd2,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [REG_AW-1:0]    id_rs1,
    input  logic [REG_AW-1:0]    id_rs2,
    input  logic [REG_AW-1:0]    id_rd,
    input  logic [ALUCTRL_W-1:0] id_alu_ctrl,
    input  logic                 id_alu_src_a,
    input  logic                 id_alu_src_b,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 flush,
    input  logic                 mem_reg_write,
    input  logic [REG_AW-1:0]    mem_rd,
    input  logic [XLEN-1:0]      mem_result,
    input  logic                 wb_reg_write,
    input  logic [REG_AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]      wb_result,
    output logic                 hazard_stall,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [XLEN-1:0]      ex_store_data,
    output logic                 ex_valid,
    output logic [REG_AW-1:0]    ex_rd,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic [XLEN-1:0]      ex_pc
);
    ex_regs_t        ex;
    ex_regs_t        id_fields;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign id_fields = '{valid: 1'b1, reg_write: id_reg_write, mem_read: id_mem_read,
                         mem_write: id_mem_write, alu_src_a: id_alu_src_a,
                         alu_src_b: id_alu_src_b, alu_ctrl: id_alu_ctrl, rs1: id_rs1,
                         rs2: id_rs2, rd: id_rd, pc: id_pc, rd1: id_rd1, rd2: id_rd2,
                         imm: id_imm};

    assign hazard_stall = ex.valid && ex.mem_read && ex.rd != '0 && id_valid
                          && (id_rs1 == ex.rd || id_rs2 == ex.rd);

    always_ff @(posedge clk)
        ex <= (!rst_n || flush || hazard_stall || !id_valid) ? ex_bubble() : id_fields;

    fwd_mux u_fwd_rs1 (
        .rs(ex.rs1), .reg_data(ex.rd1),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .data(fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs(ex.rs2), .reg_data(ex.rd2),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .data(fwd_rs2)
    );

    assign alu_a         = ex.alu_src_a ? ex.pc : fwd_rs1;
    assign alu_b         = ex.alu_src_b ? ex.imm : fwd_rs2;
    assign alu_ctrl      = ex.alu_ctrl;
    assign ex_store_data = fwd_rs2;
    assign ex_valid      = ex.valid;
    assign ex_rd         = ex.rd;
    assign ex_reg_write  = ex.reg_write;
    assign ex_mem_read   = ex.mem_read;
    assign ex_mem_write  = ex.mem_write;
    assign ex_pc         = ex.pc;
endmodule
